bounce_physics_engine: RTL and testbench

BOUNCE_PHYSICS_ENGINE -- requirements
Module: bounce_physics_engine

---
 rtl/bounce_pkg.sv | 16 +
 rtl/bounce_alu.sv | 79 +++++++
 rtl/bounce_physics_engine.sv | 175 +++++++++++++++++
 tb/tb_bounce_physics_engine.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared FSM encoding and default Q8.24 constants
// for the multi-channel bounce engine.
package bounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] GRAVITY_D  = 32'd3355;
  localparam logic [31:0] KICK_V_D   = 32'h03000000;
  localparam logic [31:0] CEIL_D     = 32'h0A000000;
  localparam logic [31:0] LED_STEP_D = 32'd1677721;

endpackage

// File: rtl/bounce_alu.sv
// Per-channel next-state datapath: gravity, kick,
// position integration, floor/ceiling reflection.
module bounce_alu
  import bounce_pkg::*;
#(
  parameter int                  W         = 32,
  parameter logic signed [W-1:0] GRAVITY   = W'(GRAVITY_D),
  parameter int                  VEL_SHIFT = 16,
  parameter int                  RST_SHIFT = 2,
  parameter logic signed [W-1:0] CEIL      = W'(CEIL_D),
  parameter logic signed [W-1:0] KICK_V    = W'(KICK_V_D)
) (
  input  logic signed [W-1:0] i_p,
  input  logic signed [W-1:0] i_v,
  input  logic [7:0]          i_cnt,
  input  logic                i_kick,
  output logic signed [W-1:0] o_p,
  output logic signed [W-1:0] o_v,
  output logic [7:0]          o_cnt
);

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ZERO = '0;

  function automatic logic signed [W-1:0] sat(
    input logic [W:0] s
  );
    if (s[W] != s[W-1]) return s[W] ? SMIN : SMAX;
    return s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sadd(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    return sat({a[W-1], a} + {b[W-1], b});
  endfunction

  function automatic logic signed [W-1:0] ssub(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    return sat({a[W-1], a} - {b[W-1], b});
  endfunction

  function automatic logic signed [W-1:0] sneg(
    input logic signed [W-1:0] a
  );
    return (a == SMIN) ? SMAX : -a;
  endfunction

  logic signed [W-1:0] w_vg;
  logic signed [W-1:0] w_vk;
  logic signed [W-1:0] w_pn;
  logic signed [W-1:0] w_vr;

  // one full channel step from the old p and v
  always_comb begin
    w_vg = ssub(i_v, GRAVITY);
    w_vk = w_vg;
    if (i_kick)
      w_vk = (w_vg <= ZERO) ? KICK_V : sadd(w_vg, KICK_V);
    w_pn = sadd(i_p, i_v >>> VEL_SHIFT);
    w_vr = ssub(w_vk, w_vk >>> RST_SHIFT);
    o_p = w_pn;
    o_v = w_vk;
    o_cnt = i_cnt;
    if (w_pn <= ZERO && w_vk < ZERO) begin
      o_p = ZERO;
      o_v = sneg(w_vr);
      o_cnt = (i_cnt == 8'hFF) ? i_cnt : i_cnt + 8'd1;
    end else if (w_pn >= CEIL && w_vk > ZERO) begin
      o_p = CEIL;
      o_v = sneg(w_vk);
    end
  end

endmodule

// File: rtl/bounce_physics_engine.sv
// N-channel bouncing-ball engine: one shared ALU
// walks all channels per tick, plus an LED bar view.
module bounce_physics_engine
  import bounce_pkg::*;
#(
  parameter int                  N_CH      = 4,
  parameter int                  W         = 32,
  parameter int                  FRAC      = 24,
  parameter logic signed [W-1:0] GRAVITY   = W'(GRAVITY_D),
  parameter int                  VEL_SHIFT = 16,
  parameter int                  RST_SHIFT = 2,
  parameter logic signed [W-1:0] CEIL      = W'(CEIL_D),
  parameter logic signed [W-1:0] KICK_V    = W'(KICK_V_D),
  parameter logic signed [W-1:0] INIT_POS  = W'(1000),
  parameter logic signed [W-1:0] INIT_VEL  = W'(3) << FRAC,
  parameter int                  LED_N     = 10,
  parameter logic signed [W-1:0] LED_STEP  = W'(LED_STEP_D),
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                CLOCK_50,
  input  logic                Reset,
  input  logic                tick,
  input  logic                restart,
  input  logic [N_CH-1:0]     kick,
  input  logic [IW-1:0]       sel,
  output logic [N_CH*W-1:0]   position,
  output logic [N_CH*W-1:0]   velocity,
  output logic [N_CH*8-1:0]   bounce_cnt,
  output logic [LED_N-1:0]    led,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int KW = (LED_N > 1) ? $clog2(LED_N) : 1;
  localparam int WX = 2 * W;

  state_t              r_state;
  state_t              w_nstate;
  logic [IW-1:0]       r_idx;
  logic signed [W-1:0] r_p [N_CH];
  logic signed [W-1:0] r_v [N_CH];
  logic [7:0]          r_cnt [N_CH];
  logic [N_CH-1:0]     r_pend;
  logic                r_ovr;
  logic [LED_N-1:0]    r_led;
  logic                w_last;
  logic [N_CH-1:0]     w_slot;
  logic signed [W-1:0] w_np;
  logic signed [W-1:0] w_nv;
  logic [7:0]          w_ncnt;
  logic signed [W-1:0] w_psel;
  logic [KW-1:0]       w_k;

  assign w_last = (r_idx == IW'(N_CH - 1));

  // FSM state register
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // next state and status strobes; restart wins
  always_comb begin
    w_nstate = r_state;
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_IDLE:   if (tick) w_nstate = S_UPDATE;
      S_UPDATE: begin
        busy = 1'b1;
        if (w_last) w_nstate = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        w_nstate = S_IDLE;
      end
      default:  w_nstate = S_IDLE;
    endcase
    if (restart) w_nstate = S_IDLE;
  end

  // channel slot counter, restarts at 0 each pass
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset)
      r_idx <= '0;
    else if (r_state == S_UPDATE && !restart)
      r_idx <= r_idx + 1'b1;
    else
      r_idx <= '0;
  end

  // one-hot of the channel owning this cycle's slot
  always_comb begin
    w_slot = '0;
    if (r_state == S_UPDATE) w_slot[r_idx] = 1'b1;
  end

  bounce_alu #(
    .W         (W),
    .GRAVITY   (GRAVITY),
    .VEL_SHIFT (VEL_SHIFT),
    .RST_SHIFT (RST_SHIFT),
    .CEIL      (CEIL),
    .KICK_V    (KICK_V)
  ) u_alu (
    .i_p   (r_p[r_idx]),
    .i_v   (r_v[r_idx]),
    .i_cnt (r_cnt[r_idx]),
    .i_kick(r_pend[r_idx]),
    .o_p   (w_np),
    .o_v   (w_nv),
    .o_cnt (w_ncnt)
  );

  // per-channel state, pending kicks, write-back
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_p[i]   <= INIT_POS;
        r_v[i]   <= INIT_VEL;
        r_cnt[i] <= '0;
      end
      r_pend <= '0;
    end else if (restart) begin
      for (int i = 0; i < N_CH; i++) begin
        r_p[i]   <= INIT_POS;
        r_v[i]   <= INIT_VEL;
        r_cnt[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_slot) | kick;
      if (r_state == S_UPDATE) begin
        r_p[r_idx]   <= w_np;
        r_v[r_idx]   <= w_nv;
        r_cnt[r_idx] <= w_ncnt;
      end
    end
  end

  // sticky flag: tick seen outside IDLE
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset)
      r_ovr <= 1'b0;
    else if (tick && !restart && r_state != S_IDLE)
      r_ovr <= 1'b1;
  end

  // LED index: highest threshold the position reaches
  always_comb begin
    w_psel = r_p[sel];
    w_k = '0;
    for (int j = 1; j < LED_N; j++) begin
      if (WX'(w_psel) >= WX'(j) * WX'(LED_STEP))
        w_k = KW'(j);
    end
  end

  // registered one-hot LED bar
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) r_led <= LED_N'(1);
    else       r_led <= LED_N'(1) << w_k;
  end

  assign led     = r_led;
  assign overrun = r_ovr;

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign position[g*W +: W]   = r_p[g];
    assign velocity[g*W +: W]   = r_v[g];
    assign bounce_cnt[g*8 +: 8] = r_cnt[g];
  end

endmodule

// File: tb/tb_bounce_physics_engine.sv
// Self-checking bench: scenario tasks plus a
// wide-integer reference model of the ball physics.
module tb_bounce_physics_engine;

  localparam int N = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;
  localparam longint KICK = 64'sd50331648;
  localparam longint CEIL = 64'sd167772160;
  localparam longint STEP = 64'sd1677721;
  localparam longint IPOS = 64'sd1000;
  localparam longint IVEL = 64'sd50331648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tick = 1'b0;
  logic restart = 1'b0;
  logic [3:0] kick = '0;
  logic [3:0] kick_e = 4'hF;
  logic [1:0] sel = '0;

  logic [127:0] pos, vel, pos_b, vel_b, pos_c, vel_c;
  logic [127:0] pos_d, vel_d, pos_e, vel_e;
  logic [31:0] cnt, cnt_b, cnt_c, cnt_d, cnt_e;
  logic [9:0] led, led_b, led_c, led_d, led_e;
  logic busy, done, ovr;
  logic busy_b, done_b, ovr_b, busy_c, done_c, ovr_c;
  logic busy_d, done_d, ovr_d, busy_e, done_e, ovr_e;

  bounce_physics_engine u_dut (
    .CLOCK_50(clk), .Reset(rst), .tick(tick),
    .restart(restart), .kick(kick), .sel(sel),
    .position(pos), .velocity(vel),
    .bounce_cnt(cnt), .led(led), .busy(busy),
    .done(done), .overrun(ovr)
  );

  bounce_physics_engine #(
    .INIT_POS(0), .INIT_VEL(-16777216)
  ) u_floor (
    .CLOCK_50(clk), .Reset(rst), .tick(tick),
    .restart(restart), .kick(kick), .sel(sel),
    .position(pos_b), .velocity(vel_b),
    .bounce_cnt(cnt_b), .led(led_b), .busy(busy_b),
    .done(done_b), .overrun(ovr_b)
  );

  bounce_physics_engine #(
    .INIT_POS(32'h09FFFF00), .INIT_VEL(32'h01000000)
  ) u_ceil (
    .CLOCK_50(clk), .Reset(rst), .tick(tick),
    .restart(restart), .kick(kick), .sel(sel),
    .position(pos_c), .velocity(vel_c),
    .bounce_cnt(cnt_c), .led(led_c), .busy(busy_c),
    .done(done_c), .overrun(ovr_c)
  );

  bounce_physics_engine #(
    .INIT_POS(5033168), .INIT_VEL(0)
  ) u_led (
    .CLOCK_50(clk), .Reset(rst), .tick(tick),
    .restart(restart), .kick(kick), .sel(sel),
    .position(pos_d), .velocity(vel_d),
    .bounce_cnt(cnt_d), .led(led_d), .busy(busy_d),
    .done(done_d), .overrun(ovr_d)
  );

  bounce_physics_engine #(
    .INIT_POS(0), .INIT_VEL(32'h7FFFFF00)
  ) u_sat (
    .CLOCK_50(clk), .Reset(rst), .tick(tick),
    .restart(restart), .kick(kick_e), .sel(sel),
    .position(pos_e), .velocity(vel_e),
    .bounce_cnt(cnt_e), .led(led_e), .busy(busy_e),
    .done(done_e), .overrun(ovr_e)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  longint mp [N];
  longint mv [N];
  int mc [N];
  logic [N-1:0] mpend;

  function automatic longint ch_of(input logic [127:0] b, input int i);
    return longint'($signed(b[i*32 +: 32]));
  endfunction

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mp[i] = IPOS; mv[i] = IVEL; mc[i] = 0;
    end
    mpend = '0;
  endtask

  task automatic model_pass();
    longint vg, vk, pn;
    for (int i = 0; i < N; i++) begin
      vg = sat(mv[i] - 3355);
      if (mpend[i]) vk = (vg <= 0) ? KICK : sat(vg + KICK);
      else vk = vg;
      pn = sat(mp[i] + (mv[i] >>> 16));
      if (pn <= 0 && vk < 0) begin
        mp[i] = 0;
        mv[i] = sat(-sat(vk - (vk >>> 2)));
        mc[i] = (mc[i] == 255) ? 255 : mc[i] + 1;
      end else if (pn >= CEIL && vk > 0) begin
        mp[i] = CEIL;
        mv[i] = sat(-vk);
      end else begin
        mp[i] = pn;
        mv[i] = vk;
      end
      mpend[i] = 1'b0;
    end
  endtask

  function automatic logic [9:0] model_led(input longint p);
    longint k;
    logic [9:0] one;
    one = 10'd1;
    k = (p < 0) ? 0 : p / STEP;
    if (k > 9) k = 9;
    return one << k;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic run_pass(output int lat);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got b%b d%b o%b want 000",
               busy, done, ovr);
    end
    checks++;
    if (led !== 10'd1) begin
      errors++;
      $display("FAIL reset_led got %h want 001", led);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(pos, i) !== IPOS || ch_of(vel, i) !== IVEL
          || cnt[i*8 +: 8] !== 8'd0) begin
        errors++;
        $display("FAIL reset_ch%0d got p=%0d v=%0d c=%0d",
                 i, ch_of(pos, i), ch_of(vel, i), cnt[i*8 +: 8]);
      end
    end
    rst = 1'b0;
    cyc();
    model_reset();
  endtask

  task automatic test_first_tick();
    int lat;
    run_pass(lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL first_latency got %0d want 5", lat);
    end
    model_pass();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(pos, i) !== 1768 || ch_of(vel, i) !== 50328293
          || cnt[i*8 +: 8] !== 8'd0) begin
        errors++;
        $display("FAIL first_ch%0d got p=%0d v=%0d c=%0d",
                 i, ch_of(pos, i), ch_of(vel, i), cnt[i*8 +: 8]);
      end
      checks++;
      if (ch_of(pos_b, i) !== 0 || ch_of(vel_b, i) !== 12585428
          || cnt_b[i*8 +: 8] !== 8'd1) begin
        errors++;
        $display("FAIL floor_ch%0d got p=%0d v=%0d c=%0d",
                 i, ch_of(pos_b, i), ch_of(vel_b, i), cnt_b[i*8 +: 8]);
      end
      checks++;
      if (ch_of(pos_c, i) !== CEIL || ch_of(vel_c, i) !== -16773861) begin
        errors++;
        $display("FAIL ceil_ch%0d got p=%0d v=%0d",
                 i, ch_of(pos_c, i), ch_of(vel_c, i));
      end
      checks++;
      if (ch_of(pos_e, i) !== 32767 || ch_of(vel_e, i) !== SMAX) begin
        errors++;
        $display("FAIL sat_ch%0d got p=%0d v=%0d",
                 i, ch_of(pos_e, i), ch_of(vel_e, i));
      end
    end
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width got d%b b%b want 0 0", done, busy);
    end
    cyc();
    checks++;
    if (led_c !== 10'h200 || led_d !== 10'h008 || led_b !== 10'h001) begin
      errors++;
      $display("FAIL led_bar got c=%h d=%h b=%h want 200 008 001",
               led_c, led_d, led_b);
    end
  endtask

  task automatic test_kick();
    int lat;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    model_reset();
    kick = 4'b0100;
    cyc();
    kick = '0;
    mpend[2] = 1'b1;
    run_pass(lat);
    model_pass();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(vel, i) !== ((i == 2) ? 100659941 : 50328293)
          || ch_of(vel, i) !== mv[i] || ch_of(pos, i) !== mp[i]) begin
        errors++;
        $display("FAIL kick_ch%0d got v=%0d want %0d", i,
                 ch_of(vel, i), mv[i]);
      end
    end
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    kick = 4'b0010;
    cyc();
    kick = '0;
    wait_done(lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL slot_pass got timeout want done");
    end
    model_pass();
    mpend[1] = 1'b1;
    cyc();
    run_pass(lat);
    model_pass();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(vel, i) !== mv[i] || ch_of(pos, i) !== mp[i]) begin
        errors++;
        $display("FAIL slot_kick_ch%0d got v=%0d p=%0d want %0d %0d",
                 i, ch_of(vel, i), ch_of(pos, i), mv[i], mp[i]);
      end
    end
    cyc();
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    model_pass();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL overrun_done got %0d pulses want 1", done_cnt - d0);
    end
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", ovr);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(vel, i) !== mv[i] || ch_of(pos, i) !== mp[i]) begin
        errors++;
        $display("FAIL overrun_ch%0d got v=%0d want %0d",
                 i, ch_of(vel, i), mv[i]);
      end
    end
  endtask

  task automatic test_restart();
    int d0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    d0 = done_cnt;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy got %b want 0", busy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(pos, i) !== IPOS || ch_of(vel, i) !== IVEL
          || cnt[i*8 +: 8] !== 8'd0) begin
        errors++;
        $display("FAIL restart_ch%0d got p=%0d v=%0d",
                 i, ch_of(pos, i), ch_of(vel, i));
      end
    end
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (done_cnt !== d0 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL restart_nodone got %0d pulses ovr=%b want 0 1",
               done_cnt - d0, ovr);
    end
    model_reset();
  endtask

  task automatic test_reset_midpass();
    int d0, lat;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0
        || led !== 10'd1) begin
      errors++;
      $display("FAIL midreset_flags got b%b d%b o%b led=%h",
               busy, done, ovr, led);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(pos, i) !== IPOS || ch_of(vel, i) !== IVEL
          || cnt[i*8 +: 8] !== 8'd0) begin
        errors++;
        $display("FAIL midreset_ch%0d got p=%0d v=%0d",
                 i, ch_of(pos, i), ch_of(vel, i));
      end
    end
    cyc();
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL midreset_nodone got %0d pulses want 0",
               done_cnt - d0);
    end
    model_reset();
    run_pass(lat);
    model_pass();
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL midreset_latency got %0d want 5", lat);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_of(vel, i) !== mv[i] || ch_of(pos, i) !== mp[i]) begin
        errors++;
        $display("FAIL midreset_pass_ch%0d got v=%0d want %0d",
                 i, ch_of(vel, i), mv[i]);
      end
    end
    cyc();
  endtask

  task automatic test_random();
    int lat, idle;
    logic [9:0] exp_led;
    for (int it = 0; it < 25; it++) begin
      idle = $urandom_range(1, 3);
      sel = 2'($urandom);
      for (int c = 0; c < idle; c++) begin
        kick = 4'($urandom) & 4'($urandom);
        mpend = mpend | kick;
        cyc();
      end
      kick = '0;
      run_pass(lat);
      model_pass();
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL rand_latency it%0d got %0d want 5", it, lat);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ch_of(vel, i) !== mv[i] || ch_of(pos, i) !== mp[i]
            || cnt[i*8 +: 8] !== 8'(mc[i])) begin
          errors++;
          $display("FAIL rand_ch%0d it%0d got p=%0d v=%0d want %0d %0d",
                   i, it, ch_of(pos, i), ch_of(vel, i), mp[i], mv[i]);
        end
      end
      cyc();
      exp_led = model_led(mp[sel]);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL rand_led it%0d got %h want %h", it, led, exp_led);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_tick();
    test_kick();
    test_overrun();
    test_restart();
    test_reset_midpass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
